// File: rtl/ucsbece154_mem_arbiter_if.sv
// Bus bundle between the instruction cache, the data cache, the SDRAM
// controller and the memory arbiter that shares the SDRAM between them.
// The arbiter connects through the slave modport; whatever drives the cache
// requests and the SDRAM beats connects through the master modport.
interface ucsbece154_mem_arbiter_if;
  // Instruction-cache side
  logic        IMemReadRequest;
  logic [31:0] IMemReadAddress;
  logic        IAbort;
  logic [31:0] IMemDataOut;
  logic        IMemDataReady;
  // Data-cache side
  logic        DMemReadRequest;
  logic [31:0] DMemReadAddress;
  logic [31:0] DMemDataOut;
  logic        DMemDataReady;
  // SDRAM controller side
  logic [31:0] MemReadAddress;
  logic        MemReadRequest;
  logic [31:0] MemDataIn;
  logic        MemDataReady;
  // Owner status: 00 none, 01 I, 10 D, 11 draining an aborted I burst
  logic [1:0]  Grant;

  modport slave (
    input  IMemReadRequest, IMemReadAddress, IAbort,
    input  DMemReadRequest, DMemReadAddress,
    input  MemDataIn, MemDataReady,
    output IMemDataOut, IMemDataReady,
    output DMemDataOut, DMemDataReady,
    output MemReadAddress, MemReadRequest,
    output Grant
  );

  modport master (
    output IMemReadRequest, IMemReadAddress, IAbort,
    output DMemReadRequest, DMemReadAddress,
    output MemDataIn, MemDataReady,
    input  IMemDataOut, IMemDataReady,
    input  DMemDataOut, DMemDataReady,
    input  MemReadAddress, MemReadRequest,
    input  Grant
  );
endinterface

// File: rtl/ucsbece154_mem_arbiter.sv
// Round-robin arbiter sharing one burst-read SDRAM port between the
// instruction and data caches. A granted burst always runs to completion
// (BLOCK_WORDS beats); an instruction-side abort turns the remainder of the
// burst into a silent drain so the SDRAM controller is never left mid-burst.
module ucsbece154_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_ALIGN  = $clog2(BLOCK_WORDS) + 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  ucsbece154_mem_arbiter_if.slave     bus
);

  localparam int CW = $clog2(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BLOCK_WORDS - 1);
  localparam logic [31:0]   ALIGN_MASK = {32{1'b1}} << ADDR_ALIGN;

  // last_grant encoding: which side owned the most recent burst
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    DRAIN  = 2'b11
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_beat_cnt;
  logic            r_last_grant;
  logic            r_mem_req;
  logic [31:0]     r_mem_addr;
  logic [1:0]      r_grant;

  logic            w_win_i;
  logic            w_win_d;
  logic            w_final_beat;

  // Round-robin winner selection in IDLE: a lone requester wins, a tie goes
  // to the side that did not own the previous burst.
  always_comb begin
    w_win_i = 1'b0;
    w_win_d = 1'b0;
    if (bus.IMemReadRequest && bus.DMemReadRequest) begin
      w_win_i = (r_last_grant == LG_D);
      w_win_d = (r_last_grant == LG_I);
    end else if (bus.IMemReadRequest) begin
      w_win_i = 1'b1;
    end else if (bus.DMemReadRequest) begin
      w_win_d = 1'b1;
    end else begin
      w_win_i = 1'b0;
      w_win_d = 1'b0;
    end
  end

  // The beat that completes the burst (only meaningful outside IDLE)
  assign w_final_beat = bus.MemDataReady && (r_beat_cnt == LAST_BEAT);

  // Burst sequencing: grant, beat counting, abort drain and completion
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_beat_cnt   <= {CW{1'b0}};
      r_last_grant <= LG_D;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_grant      <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          // MemDataReady is ignored here; the counter only moves in a burst
          if (w_win_i) begin
            r_state      <= BUSY_I;
            r_mem_addr   <= bus.IMemReadAddress & ALIGN_MASK;
            r_mem_req    <= 1'b1;
            r_beat_cnt   <= {CW{1'b0}};
            r_last_grant <= LG_I;
            r_grant      <= 2'b01;
          end else if (w_win_d) begin
            r_state      <= BUSY_D;
            r_mem_addr   <= bus.DMemReadAddress & ALIGN_MASK;
            r_mem_req    <= 1'b1;
            r_beat_cnt   <= {CW{1'b0}};
            r_last_grant <= LG_D;
            r_grant      <= 2'b10;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY_I: begin
          if (bus.MemDataReady) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
          if (w_final_beat) begin
            // An abort on the last beat just suppresses that beat
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_grant   <= 2'b00;
          end else if (bus.IAbort) begin
            r_state <= DRAIN;
            r_grant <= 2'b11;
          end else begin
            r_state <= BUSY_I;
          end
        end
        BUSY_D, DRAIN: begin
          // IAbort has no meaning for a data burst or an ongoing drain
          if (bus.MemDataReady) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
          if (w_final_beat) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_grant   <= 2'b00;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_mem_req  <= 1'b0;
          r_beat_cnt <= {CW{1'b0}};
          r_grant    <= 2'b00;
        end
      endcase
    end
  end

  // Data passes straight through; the ready strobes steer it to one side
  assign bus.IMemDataOut    = bus.MemDataIn;
  assign bus.DMemDataOut    = bus.MemDataIn;
  assign bus.IMemDataReady  = bus.MemDataReady && (r_state == BUSY_I) && !bus.IAbort;
  assign bus.DMemDataReady  = bus.MemDataReady && (r_state == BUSY_D);
  assign bus.MemReadAddress = r_mem_addr;
  assign bus.MemReadRequest = r_mem_req;
  assign bus.Grant          = r_grant;

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Directed bench for the memory arbiter. Stimulus pushes every ready strobe
// it expects (side + data) into a queue; a monitor on the falling edge pops
// and compares whenever the DUT raises a ready, and flags any strobe that
// was not expected. Grant/address/request state is checked inline.
module tb_ucsbece154_mem_arbiter;

  logic Clk;
  logic Reset;

  ucsbece154_mem_arbiter_if bus();

  ucsbece154_mem_arbiter #(.BLOCK_WORDS(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        side;   // 0 = I, 1 = D
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present one SDRAM beat for one cycle; optionally expect a ready strobe
  task automatic beat(input logic [31:0] d, input logic push, input logic side);
    bus.MemDataIn    = d;
    bus.MemDataReady = 1'b1;
    if (push) exp_q.push_back({side, d});
    step();
    bus.MemDataReady = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [1:0] g, input logic req);
    check({name, "_grant"}, 64'(bus.Grant), 64'(g));
    check({name, "_memreq"}, 64'(bus.MemReadRequest), 64'(req));
  endtask

  // Scoreboard monitor: compare every presented ready strobe
  always @(negedge Clk) begin
    exp_t e;
    if (bus.IMemDataReady || bus.DMemDataReady) begin
      if (bus.IMemDataReady && bus.DMemDataReady) begin
        n_total++;
        $display("FAIL both_ready: I and D strobes together, expected at most one (t=%0t)", $time);
      end else if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: I=%0b D=%0b data=%h, expected no strobe (t=%0t)",
                 bus.IMemDataReady, bus.DMemDataReady, bus.MemDataIn, $time);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({bus.DMemDataReady,
                          bus.DMemDataReady ? bus.DMemDataOut : bus.IMemDataOut}),
              64'(e));
      end
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    bus.IMemReadRequest = 1'b0;
    bus.IMemReadAddress = 32'h0;
    bus.IAbort          = 1'b0;
    bus.DMemReadRequest = 1'b0;
    bus.DMemReadAddress = 32'h0;
    bus.MemDataIn       = 32'h0;
    bus.MemDataReady    = 1'b0;
    #2;
    check_state("reset", 2'b00, 1'b0);
    check("reset_addr", 64'(bus.MemReadAddress), 64'h0);
    step();
    step();
    Reset = 1'b0;
    step();

    // Single I burst with alignment of 0x0001_0034
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0034;
    step();
    check_state("i_grant", 2'b01, 1'b1);
    check("i_addr", 64'(bus.MemReadAddress), 64'h0001_0030);
    bus.IMemReadRequest = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hA0 + 32'(i), 1'b1, 1'b0);
    check_state("i_done", 2'b00, 1'b0);

    // Round-robin after a fresh reset: I first, then D, then I again
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0100;
    bus.DMemReadRequest = 1'b1;
    bus.DMemReadAddress = 32'h0002_0008;
    step();
    check_state("rr1", 2'b01, 1'b1);
    check("rr1_addr", 64'(bus.MemReadAddress), 64'h0001_0100);
    for (int i = 0; i < 4; i++) beat(32'hB0 + 32'(i), 1'b1, 1'b0);
    check_state("rr1_gap", 2'b00, 1'b0);
    step();
    check_state("rr2", 2'b10, 1'b1);
    check("rr2_addr", 64'(bus.MemReadAddress), 64'h0002_0000);
    for (int i = 0; i < 4; i++) beat(32'hC0 + 32'(i), 1'b1, 1'b1);
    check_state("rr2_gap", 2'b00, 1'b0);
    step();
    check_state("rr3", 2'b01, 1'b1);
    bus.IMemReadRequest = 1'b0;
    bus.DMemReadRequest = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hD0 + 32'(i), 1'b1, 1'b0);
    check_state("rr3_done", 2'b00, 1'b0);

    // IAbort on beat 1 of an I burst -> silent drain, then pending D granted
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0200;
    step();
    check_state("ab_grant", 2'b01, 1'b1);
    bus.IMemReadRequest = 1'b0;
    bus.DMemReadRequest = 1'b1;
    bus.DMemReadAddress = 32'h0002_0040;
    bus.IAbort = 1'b1;
    beat(32'hE0, 1'b0, 1'b0);
    bus.IAbort = 1'b0;
    check_state("ab_drain", 2'b11, 1'b1);
    for (int i = 1; i < 4; i++) beat(32'hE0 + 32'(i), 1'b0, 1'b0);
    check_state("ab_done", 2'b00, 1'b0);
    step();
    check_state("ab_d_grant", 2'b10, 1'b1);
    check("ab_d_addr", 64'(bus.MemReadAddress), 64'h0002_0040);
    bus.DMemReadRequest = 1'b0;

    // IAbort held through a D burst has no effect
    bus.IAbort = 1'b1;
    for (int i = 0; i < 4; i++) beat(32'hF0 + 32'(i), 1'b1, 1'b1);
    bus.IAbort = 1'b0;
    check_state("d_abort_done", 2'b00, 1'b0);

    // IAbort on the final beat of an I burst: beat suppressed, normal finish
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0300;
    step();
    bus.IMemReadRequest = 1'b0;
    for (int i = 0; i < 3; i++) beat(32'h30 + 32'(i), 1'b1, 1'b0);
    bus.IAbort = 1'b1;
    beat(32'h33, 1'b0, 1'b0);
    bus.IAbort = 1'b0;
    check_state("last_abort", 2'b00, 1'b0);

    // Reset after beat 2 acts without a clock edge; stray beat is ignored
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0400;
    step();
    bus.IMemReadRequest = 1'b0;
    beat(32'h40, 1'b1, 1'b0);
    beat(32'h41, 1'b1, 1'b0);
    Reset = 1'b1;
    #1;
    check_state("rst_mid", 2'b00, 1'b0);
    step();
    Reset = 1'b0;
    bus.MemDataIn    = 32'h77;
    bus.MemDataReady = 1'b1;
    #2;
    check("stray_i", 64'(bus.IMemDataReady), 64'h0);
    check("stray_d", 64'(bus.DMemDataReady), 64'h0);
    step();
    bus.MemDataReady = 1'b0;

    // MemDataReady in IDLE must not disturb the next burst's length
    bus.MemDataReady = 1'b1;
    step();
    step();
    bus.MemDataReady = 1'b0;
    check_state("idle_beats", 2'b00, 1'b0);
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0500;
    step();
    bus.IMemReadRequest = 1'b0;
    for (int i = 0; i < 3; i++) beat(32'h50 + 32'(i), 1'b1, 1'b0);
    check_state("idle_b3", 2'b01, 1'b1);
    beat(32'h53, 1'b1, 1'b0);
    check_state("idle_b4", 2'b00, 1'b0);

    step();
    step();
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
